// File: rtl/handler_arb_pkg.sv
// Shared types and helpers for the handler stream arbiter and the handler wrapper.
// Holds the FSM state type, grant-width helper, round-robin search and AM header fields.
package handler_arb_pkg;

   typedef enum logic {
      ST_IDLE,
      ST_LOCKED
   } arb_state_t;

   localparam int unsigned DEFAULT_DATA_WIDTH = 64;

   // Active-message header fields, shared with the handler wrapper
   localparam int unsigned AM_DEST_LSB    = 24;
   localparam int unsigned AM_DEST_MSB    = 39;
   localparam int unsigned AM_HANDLER_LSB = 56;
   localparam int unsigned AM_HANDLER_MSB = 59;

   function automatic int unsigned src_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // First valid index after 'last', wrapping modulo n; the descending loop lets the
   // smallest offset win without an early exit.
   function automatic int unsigned rr_pick(input logic [15:0] valid,
                                           input int unsigned last,
                                           input int unsigned n);
      int unsigned idx;
      rr_pick = last;
      for (int unsigned i = n; i >= 1; i--) begin
         idx = (last + i) % n;
         if (valid[4'(idx)]) rr_pick = idx;
      end
   endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream skid buffer carrying tdata and tlast.
// Registered in_tready and out_tvalid; full throughput with one cycle of latency.
module axis_skid_buffer #(
   parameter int unsigned DATA_WIDTH = 64
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] in_tdata,
   input  logic                  in_tlast,
   input  logic                  in_tvalid,
   output logic                  in_tready,
   output logic [DATA_WIDTH-1:0] out_tdata,
   output logic                  out_tlast,
   output logic                  out_tvalid,
   input  logic                  out_tready
);

   logic [DATA_WIDTH:0] mem_q [2];
   logic                rd_ptr_q;
   logic                wr_ptr_q;
   logic [1:0]          count_q;
   logic [1:0]          count_d;
   logic                push;
   logic                pop;

   assign push = in_tvalid & in_tready;
   assign pop  = out_tvalid & out_tready;

   always_comb begin
      count_d = count_q;
      if (push && !pop) count_d = count_q + 2'd1;
      else if (pop && !push) count_d = count_q - 2'd1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         mem_q[0]   <= '0;
         mem_q[1]   <= '0;
         rd_ptr_q   <= 1'b0;
         wr_ptr_q   <= 1'b0;
         count_q    <= '0;
         in_tready  <= 1'b0;
         out_tvalid <= 1'b0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= {in_tlast, in_tdata};
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         count_q    <= count_d;
         in_tready  <= (count_d < 2'd2);
         out_tvalid <= (count_d != 2'd0);
      end
   end

   assign {out_tlast, out_tdata} = mem_q[rd_ptr_q];

endmodule

// File: rtl/handler_stream_arbiter.sv
// Packet-granular round-robin arbiter feeding the handler bank through a skid buffer.
// Optional mid-packet stall timeout is enabled by defining HANDLER_ARB_TIMEOUT_EN.
module handler_stream_arbiter
   import handler_arb_pkg::*;
#(
   parameter int unsigned NUM_SOURCES    = 2,
   parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic [NUM_SOURCES*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [NUM_SOURCES-1:0]            s_axis_tvalid,
   input  logic [NUM_SOURCES-1:0]            s_axis_tlast,
   output logic [NUM_SOURCES-1:0]            s_axis_tready,
   output logic [DATA_WIDTH-1:0]             m_axis_handler_tdata,
   output logic                              m_axis_handler_tvalid,
   output logic                              m_axis_handler_tlast,
   input  logic                              m_axis_handler_tready,
   output logic [src_w(NUM_SOURCES)-1:0]     grant_id,
   output logic                              busy
`ifdef HANDLER_ARB_TIMEOUT_EN
   ,
   output logic                              timeout_error
`endif
);

   localparam int unsigned SRC_W = src_w(NUM_SOURCES);

   if (NUM_SOURCES < 1 || NUM_SOURCES > 16 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535)
   begin : g_bad_params
      $error("handler_stream_arbiter: parameter out of range");
   end

   arb_state_t             state_q, state_d;
   logic [SRC_W-1:0]       grant_q, grant_d;
   logic [SRC_W-1:0]       last_q, last_d;
   logic                   skid_in_ready;
   logic                   skid_valid;
   logic [DATA_WIDTH-1:0]  skid_data;
   logic                   skid_last;
   logic                   flush;

`ifdef HANDLER_ARB_TIMEOUT_EN
   logic [15:0] stall_q;
   logic        accept;

   assign flush  = (state_q == ST_LOCKED) && (stall_q >= 16'(TIMEOUT_CYCLES));
   assign accept = |(s_axis_tvalid & s_axis_tready);

   // Counter freezes while the synthetic closing beat waits for buffer space
   always_ff @(posedge clock) begin
      if (reset) begin
         stall_q       <= '0;
         timeout_error <= 1'b0;
      end else begin
         if (state_q != ST_LOCKED || accept || (flush && skid_in_ready)) stall_q <= '0;
         else if (!flush && !s_axis_tvalid[grant_q]) stall_q <= stall_q + 16'd1;
         if (flush) timeout_error <= 1'b1;
      end
   end
`else
   assign flush = 1'b0;
`endif

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      last_d        = last_q;
      s_axis_tready = '0;
      skid_valid    = 1'b0;
      skid_data     = s_axis_tdata[32'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
      skid_last     = s_axis_tlast[grant_q];
      case (state_q)
         ST_IDLE: begin
            if (|s_axis_tvalid) begin
               grant_d = SRC_W'(rr_pick(16'(s_axis_tvalid), 32'(last_q), NUM_SOURCES));
               state_d = ST_LOCKED;
            end
         end
         ST_LOCKED: begin
            if (flush) begin
               skid_valid = 1'b1;
               skid_data  = '0;
               skid_last  = 1'b1;
               if (skid_in_ready) begin
                  last_d  = grant_q;
                  state_d = ST_IDLE;
               end
            end else begin
               s_axis_tready[grant_q] = skid_in_ready;
               skid_valid             = s_axis_tvalid[grant_q];
               if (s_axis_tvalid[grant_q] && skid_in_ready && s_axis_tlast[grant_q]) begin
                  last_d  = grant_q;
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         last_q  <= SRC_W'(NUM_SOURCES - 1);
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

   assign grant_id = grant_q;
   assign busy     = (state_q == ST_LOCKED);

   axis_skid_buffer #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_skid (
      .clock     (clock),
      .reset     (reset),
      .in_tdata  (skid_data),
      .in_tlast  (skid_last),
      .in_tvalid (skid_valid),
      .in_tready (skid_in_ready),
      .out_tdata (m_axis_handler_tdata),
      .out_tlast (m_axis_handler_tlast),
      .out_tvalid(m_axis_handler_tvalid),
      .out_tready(m_axis_handler_tready)
   );

endmodule

// File: tb/tb_handler_stream_arbiter.sv
// Self-checking bench for handler_stream_arbiter: directed scenarios plus randomized
// traffic checked against a packet-level round-robin model.
module tb_handler_stream_arbiter;
   import handler_arb_pkg::*;

   localparam int unsigned NS = 2;
   localparam int unsigned DW = 64;

   logic              clock = 1'b0;
   logic              reset;
   logic [NS*DW-1:0]  s_tdata;
   logic [NS-1:0]     s_tvalid, s_tlast, s_tready;
   logic [DW-1:0]     m_tdata;
   logic              m_tvalid, m_tlast, m_tready;
   logic [0:0]        grant_id;
   logic              busy;
`ifdef HANDLER_ARB_TIMEOUT_EN
   logic              timeout_error;
`endif

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // Source beat queues: bit DW is tlast
   logic [DW:0]   src_q [NS][$];
   logic [NS-1:0] in_pkt;
   logic [NS-1:0] hold;
   int            gap_pct;
   int            ready_pct;
   bit            ready_manual;

   logic [DW:0]   out_q[$];
   int            out_cyc[$];
   logic [NS-1:0] acc_log[$];
   logic [NS-1:0] sr_log[$];
   logic          busy_log[$];
   logic [0:0]    grant_log[$];
   logic          mv_log[$];
   logic          mr_log[$];
   logic [DW-1:0] md_log[$];

`ifdef HANDLER_ARB_TIMEOUT_EN
   handler_stream_arbiter #(
      .NUM_SOURCES   (NS),
      .DATA_WIDTH    (DW),
      .TIMEOUT_CYCLES(8)
   ) dut (
`else
   handler_stream_arbiter #(
      .NUM_SOURCES(NS),
      .DATA_WIDTH (DW)
   ) dut (
`endif
      .clock                (clock),
      .reset                (reset),
      .s_axis_tdata         (s_tdata),
      .s_axis_tvalid        (s_tvalid),
      .s_axis_tlast         (s_tlast),
      .s_axis_tready        (s_tready),
      .m_axis_handler_tdata (m_tdata),
      .m_axis_handler_tvalid(m_tvalid),
      .m_axis_handler_tlast (m_tlast),
      .m_axis_handler_tready(m_tready),
      .grant_id             (grant_id),
      .busy                 (busy)
`ifdef HANDLER_ARB_TIMEOUT_EN
      ,
      .timeout_error        (timeout_error)
`endif
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic drive();
      logic gap;
      for (int k = 0; k < NS; k++) begin
         gap = (in_pkt[k] && ($urandom_range(99) < gap_pct)) || hold[k];
         s_tvalid[k] = (src_q[k].size() != 0) && !gap;
         s_tdata[k*DW +: DW] = (src_q[k].size() != 0) ? src_q[k][0][DW-1:0] : '0;
         s_tlast[k] = (src_q[k].size() != 0) ? src_q[k][0][DW] : 1'b0;
      end
      if (!ready_manual) m_tready = ($urandom_range(99) < ready_pct);
   endtask

   task automatic step();
      logic [NS-1:0] acc;
      @(negedge clock);
      acc = s_tvalid & s_tready;
      acc_log.push_back(acc);
      sr_log.push_back(s_tready);
      busy_log.push_back(busy);
      grant_log.push_back(grant_id);
      mv_log.push_back(m_tvalid);
      mr_log.push_back(m_tready);
      md_log.push_back(m_tdata);
      if (m_tvalid && m_tready) begin
         out_q.push_back({m_tlast, m_tdata});
         out_cyc.push_back(cyc);
      end
      @(posedge clock);
      #1;
      cyc++;
      for (int k = 0; k < NS; k++) begin
         if (acc[k]) begin
            in_pkt[k] = !src_q[k][0][DW];
            void'(src_q[k].pop_front());
         end
      end
      drive();
   endtask

   task automatic run_until(input int n, input int budget);
      int c = 0;
      while (out_q.size() < n && c < budget) begin
         step();
         c++;
      end
   endtask

   task automatic clear_logs();
      out_q.delete(); out_cyc.delete(); acc_log.delete(); sr_log.delete();
      busy_log.delete(); grant_log.delete(); mv_log.delete(); mr_log.delete(); md_log.delete();
   endtask

   task automatic clear_sources();
      for (int k = 0; k < NS; k++) src_q[k].delete();
      in_pkt = '0;
      hold   = '0;
   endtask

   task automatic do_reset();
      clear_sources();
      gap_pct      = 0;
      ready_pct    = 100;
      ready_manual = 1'b0;
      reset        = 1'b1;
      drive();
      step();
      step();
      reset = 1'b0;
      clear_logs();
   endtask

   task automatic push_pkt(input int k, input logic [DW-1:0] base, input int len);
      logic [DW-1:0] d;
      for (int b = 0; b < len; b++) begin
         d = base + DW'(b);
         src_q[k].push_back({(b == len - 1), d});
      end
   endtask

   task automatic test_reset();
      clear_sources();
      push_pkt(0, 64'h11, 2);
      push_pkt(1, 64'h22, 2);
      ready_manual = 1'b0;
      ready_pct    = 100;
      gap_pct      = 0;
      reset        = 1'b1;
      drive();
      step();
      step();
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b expected 0", m_tvalid); end
      checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b expected 0", m_tlast); end
      checks++; if (m_tdata !== '0) begin errors++; $display("FAIL reset_tdata: got %h expected 0", m_tdata); end
      checks++; if (s_tready !== '0) begin errors++; $display("FAIL reset_sready: got %b expected 00", s_tready); end
      checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL reset_grant: got %0d expected 0", grant_id); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
`ifdef HANDLER_ARB_TIMEOUT_EN
      checks++; if (timeout_error !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", timeout_error); end
`endif
      reset = 1'b0;
      clear_sources();
      clear_logs();
   endtask

   task automatic test_back_to_back();
      logic [DW:0] exp [6];
      logic [DW:0] got;
      int          grants[$];
      do_reset();
      push_pkt(0, 64'h100, 3);
      push_pkt(1, 64'h200, 3);
      for (int i = 0; i < 3; i++) begin
         exp[i]     = {(i == 2), 64'h100 + 64'(i)};
         exp[i + 3] = {(i == 2), 64'h200 + 64'(i)};
      end
      drive();
      run_until(6, 40);
      step();
      checks++; if (out_q.size() != 6) begin errors++; $display("FAIL b2b_count: got %0d expected 6", out_q.size()); end
      for (int i = 0; i < 6; i++) begin
         got = (i < out_q.size()) ? out_q[i] : 'x;
         checks++; if (got !== exp[i]) begin errors++; $display("FAIL b2b_beat%0d: got %h expected %h", i, got, exp[i]); end
      end
      if (out_cyc.size() == 6) begin
         checks++; if (out_cyc[2] - out_cyc[0] != 2) begin errors++; $display("FAIL b2b_src0_contig: got span %0d expected 2", out_cyc[2] - out_cyc[0]); end
         checks++; if (out_cyc[3] - out_cyc[2] != 2) begin errors++; $display("FAIL b2b_bubble: got gap %0d expected 2", out_cyc[3] - out_cyc[2]); end
      end
      for (int i = 0; i < busy_log.size(); i++)
         if (busy_log[i] && (i == 0 || !busy_log[i-1])) grants.push_back(int'(grant_log[i]));
      checks++;
      if (grants.size() != 2 || grants[0] != 0 || grants[1] != 1) begin
         errors++; $display("FAIL b2b_grant_seq: got %p expected '{0, 1}", grants);
      end
   endtask

   task automatic test_fairness();
      int pos = -1;
      do_reset();
      for (int i = 0; i < 6; i++) push_pkt(0, 64'h300 + 64'(i), 1);
      push_pkt(1, 64'h400, 1);
      drive();
      run_until(7, 60);
      for (int i = 0; i < out_q.size(); i++)
         if (pos < 0 && out_q[i] == {1'b1, 64'h400}) pos = i;
      checks++; if (pos < 0 || pos > 1) begin errors++; $display("FAIL fairness_pos: got %0d expected 0..1", pos); end
      checks++; if (out_q.size() != 7) begin errors++; $display("FAIL fairness_count: got %0d expected 7", out_q.size()); end
   endtask

   task automatic test_backpressure();
      int          start;
      int          acc_n = 0;
      logic [DW:0] got;
      do_reset();
      push_pkt(0, 64'h500, 4);
      ready_manual = 1'b1;
      m_tready     = 1'b1;
      drive();
      step();
      step();
      start    = acc_log.size();
      m_tready = 1'b0;
      for (int i = 0; i < 5; i++) step();
      m_tready = 1'b1;
      run_until(4, 30);
      step();
      for (int i = start; i < start + 5; i++) acc_n += int'(acc_log[i][0]);
      checks++; if (acc_n > 2) begin errors++; $display("FAIL bp_accepts_while_stalled: got %0d expected <=2", acc_n); end
      checks++; if (sr_log[start + 4] !== 2'b00) begin errors++; $display("FAIL bp_sready_low: got %b expected 00", sr_log[start + 4]); end
      for (int i = start + 1; i <= start + 5; i++) begin
         if (mv_log[i-1] && !mr_log[i-1]) begin
            checks++;
            if (md_log[i] !== md_log[i-1]) begin errors++; $display("FAIL bp_stable_c%0d: got %h expected %h", i, md_log[i], md_log[i-1]); end
         end
      end
      checks++; if (out_q.size() != 4) begin errors++; $display("FAIL bp_count: got %0d expected 4", out_q.size()); end
      for (int i = 0; i < 4; i++) begin
         got = (i < out_q.size()) ? out_q[i] : 'x;
         checks++;
         if (got !== {(i == 3), 64'h500 + 64'(i)}) begin
            errors++; $display("FAIL bp_beat%0d: got %h expected %h", i, got, {(i == 3), 64'h500 + 64'(i)});
         end
      end
      ready_manual = 1'b0;
   endtask

   task automatic test_header_only();
      logic [DW-1:0] hdr;
      logic [DW:0]   got;
      logic [3:0]    hfield;
      int            busy_n = 0;
      hdr = 64'h0A00_0010_0000_0000;
      do_reset();
      src_q[1].push_back({1'b1, hdr});
      drive();
      run_until(1, 20);
      for (int i = 0; i < 4; i++) step();
      foreach (busy_log[i]) busy_n += int'(busy_log[i]);
      got    = (out_q.size() > 0) ? out_q[0] : 'x;
      hfield = got[AM_HANDLER_MSB:AM_HANDLER_LSB];
      checks++; if (out_q.size() != 1) begin errors++; $display("FAIL hdr_count: got %0d expected 1", out_q.size()); end
      checks++; if (got !== {1'b1, hdr}) begin errors++; $display("FAIL hdr_beat: got %h expected %h", got, {1'b1, hdr}); end
      checks++; if (hfield !== 4'hA) begin errors++; $display("FAIL hdr_handler_field: got %h expected a", hfield); end
      checks++; if (busy_n != 1) begin errors++; $display("FAIL hdr_busy_cycles: got %0d expected 1", busy_n); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hdr_idle_after: got busy %b expected 0", busy); end
      checks++; if (grant_id !== 1'b1) begin errors++; $display("FAIL hdr_grant_hold: got %0d expected 1", grant_id); end
   endtask

   task automatic test_reset_mid_packet();
      int          c = 0;
      logic [DW:0] got;
      do_reset();
      push_pkt(0, 64'h600, 1);
      drive();
      run_until(1, 20);
      step();
      step();
      push_pkt(1, 64'h700, 4);
      drive();
      while (src_q[1].size() > 2 && c < 20) begin step(); c++; end
      checks++; if (src_q[1].size() != 2) begin errors++; $display("FAIL rmid_progress: got %0d left expected 2", src_q[1].size()); end
      reset = 1'b1;
      step();
      checks++; if (s_tready !== 2'b00) begin errors++; $display("FAIL rmid_sready: got %b expected 00", s_tready); end
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rmid_tvalid: got %b expected 0", m_tvalid); end
      checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL rmid_grant: got %0d expected 0", grant_id); end
      reset = 1'b0;
      clear_sources();
      clear_logs();
      push_pkt(0, 64'h610, 1);
      push_pkt(1, 64'h710, 1);
      drive();
      run_until(2, 30);
      got = (out_q.size() > 0) ? out_q[0] : 'x;
      checks++; if (got !== {1'b1, 64'h610}) begin errors++; $display("FAIL rmid_priority: got %h expected %h", got, {1'b1, 64'h610}); end
   endtask

   task automatic test_random();
      logic [DW:0] cp [NS][$];
      logic [DW:0] exp[$];
      logic [DW:0] b;
      logic [DW:0] got;
      int          last;
      int          pick;
      int          kk;
      do_reset();
      gap_pct   = 30;
      ready_pct = 70;
      for (int k = 0; k < NS; k++)
         for (int p = 0; p < 8; p++)
            push_pkt(k, (64'(k) << 56) | (64'(p) << 48) | (64'($urandom) << 8), int'($urandom_range(4, 1)));
      // Packet-level model: every source with work is valid at arbitration time
      for (int k = 0; k < NS; k++) cp[k] = src_q[k];
      last = NS - 1;
      while (cp[0].size() != 0 || cp[1].size() != 0) begin
         pick = -1;
         for (int i = 1; i <= NS; i++) begin
            kk = (last + i) % NS;
            if (pick < 0 && cp[kk].size() != 0) pick = kk;
         end
         do begin
            b = cp[pick].pop_front();
            exp.push_back(b);
         end while (!b[DW]);
         last = pick;
      end
      drive();
      run_until(exp.size(), 2000);
      checks++; if (out_q.size() != exp.size()) begin errors++; $display("FAIL rand_count: got %0d expected %0d", out_q.size(), exp.size()); end
      for (int i = 0; i < exp.size(); i++) begin
         got = (i < out_q.size()) ? out_q[i] : 'x;
         checks++; if (got !== exp[i]) begin errors++; $display("FAIL rand_beat%0d: got %h expected %h", i, got, exp[i]); end
      end
   endtask

`ifdef HANDLER_ARB_TIMEOUT_EN
   task automatic test_timeout();
      int          c = 0;
      logic [DW:0] exp [4];
      logic [DW:0] got;
      do_reset();
      push_pkt(0, 64'h800, 4);
      push_pkt(1, 64'h900, 1);
      exp[0] = {1'b0, 64'h800};
      exp[1] = {1'b0, 64'h801};
      exp[2] = {1'b1, 64'h0};
      exp[3] = {1'b1, 64'h900};
      drive();
      while (src_q[0].size() > 2 && c < 20) begin step(); c++; end
      hold[0] = 1'b1;
      drive();
      run_until(4, 60);
      for (int i = 0; i < 4; i++) begin
         got = (i < out_q.size()) ? out_q[i] : 'x;
         checks++; if (got !== exp[i]) begin errors++; $display("FAIL tmo_beat%0d: got %h expected %h", i, got, exp[i]); end
      end
      for (int i = 0; i < 5; i++) step();
      checks++; if (timeout_error !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b expected 1", timeout_error); end
      hold = '0;
   endtask
`endif

   initial begin
      reset        = 1'b1;
      s_tdata      = '0;
      s_tvalid     = '0;
      s_tlast      = '0;
      m_tready     = 1'b0;
      in_pkt       = '0;
      hold         = '0;
      gap_pct      = 0;
      ready_pct    = 100;
      ready_manual = 1'b0;
      test_reset();
      test_back_to_back();
      test_fairness();
      test_backpressure();
      test_header_only();
      test_reset_mid_packet();
      test_random();
`ifdef HANDLER_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
